// File: rtl/fib_matpow_seq_if.sv
// Handshake/result bundle for the Fibonacci matrix-power engine.
// The master drives the request (start, n); the slave returns status and results.
interface fib_matpow_seq_if #(
  parameter int WIDTH = 32,
  parameter int NW    = 32
);
  logic             start;
  logic [NW-1:0]    n;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] fib;
  logic [WIDTH-1:0] fib_next;
  logic             ovf;

  modport master (
    output start, n,
    input  busy, done, fib, fib_next, ovf
  );

  modport slave (
    input  start, n,
    output busy, done, fib, fib_next, ovf
  );
endinterface

// File: rtl/fib_matpow_seq.sv
// Sequential Fibonacci engine: computes F(n) and F(n+1) as Q^n with
// Q = [[1,1],[1,0]], using LSB-first square-and-multiply, one exponent bit
// per clock. All arithmetic wraps modulo 2^WIDTH.
// Matrices are packed as {m00, m01, m10, m11}.
module fib_matpow_seq #(
  parameter int WIDTH     = 32,
  parameter int NW        = 32,
  parameter int OVF_LIMIT = 47
) (
  input  logic               clk,
  input  logic               reset,
  fib_matpow_seq_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [WIDTH-1:0]   ZERO_W = WIDTH'(0);
  localparam logic [4*WIDTH-1:0] MAT_I  = {ONE_W, ZERO_W, ZERO_W, ONE_W};
  localparam logic [4*WIDTH-1:0] MAT_Q  = {ONE_W, ONE_W, ONE_W, ZERO_W};
  localparam logic [NW-1:0]      OVF_LIM_N = NW'(OVF_LIMIT);

  // 2x2 matrix product; every term and sum is truncated to WIDTH bits.
  function automatic logic [4*WIDTH-1:0] mat_mul(
    input logic [4*WIDTH-1:0] a,
    input logic [4*WIDTH-1:0] b
  );
    logic [WIDTH-1:0] a00, a01, a10, a11;
    logic [WIDTH-1:0] b00, b01, b10, b11;
    logic [WIDTH-1:0] m00, m01, m10, m11;
    {a00, a01, a10, a11} = a;
    {b00, b01, b10, b11} = b;
    m00 = a00 * b00 + a01 * b10;
    m01 = a00 * b01 + a01 * b11;
    m10 = a10 * b00 + a11 * b10;
    m11 = a10 * b01 + a11 * b11;
    return {m00, m01, m10, m11};
  endfunction

  state_t             state_r;
  state_t             state_nx_s;
  logic [NW-1:0]      e_r;
  logic [4*WIDTH-1:0] r_r;
  logic [4*WIDTH-1:0] b_r;
  logic [4*WIDTH-1:0] r_next_s;
  logic [4*WIDTH-1:0] b_sq_s;
  logic               accept_s;
  logic               step_s;
  logic               busy_r;
  logic               done_r;
  logic               ovf_r;
  logic [WIDTH-1:0]   fib_r;
  logic [WIDTH-1:0]   fib_next_r;

  // Datapath candidates for one square-and-multiply step (old B feeds both).
  always_comb begin
    b_sq_s = mat_mul(b_r, b_r);
    if (e_r[0]) begin
      r_next_s = mat_mul(r_r, b_r);
    end else begin
      r_next_s = r_r;
    end
  end

  // Next-state logic: accept in IDLE/DONE, iterate exponent bits in RUN.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    step_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          accept_s   = 1'b1;
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (e_r == {NW{1'b0}}) begin
          state_nx_s = DONE;
        end else begin
          step_s = 1'b1;
          if (e_r[NW-1:1] == {(NW-1){1'b0}}) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = RUN;
          end
        end
      end
      DONE: begin
        if (bus.start) begin
          accept_s   = 1'b1;
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, operand registers, and registered status/result outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      e_r        <= {NW{1'b0}};
      r_r        <= {(4*WIDTH){1'b0}};
      b_r        <= {(4*WIDTH){1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ovf_r      <= 1'b0;
      fib_r      <= {WIDTH{1'b0}};
      fib_next_r <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == RUN);
      done_r  <= (state_nx_s == DONE);
      if (accept_s) begin
        e_r   <= bus.n;
        r_r   <= MAT_I;
        b_r   <= MAT_Q;
        ovf_r <= (bus.n > OVF_LIM_N);
      end else if (step_s) begin
        e_r <= e_r >> 1;
        r_r <= r_next_s;
        b_r <= b_sq_s;
      end else begin
        e_r <= e_r;
        r_r <= r_r;
        b_r <= b_r;
      end
      // Results are captured on entry to DONE so they are valid with done.
      if ((state_r == RUN) && (state_nx_s == DONE)) begin
        fib_r      <= r_next_s[3*WIDTH-1:2*WIDTH];
        fib_next_r <= r_next_s[4*WIDTH-1:3*WIDTH];
      end else begin
        fib_r      <= fib_r;
        fib_next_r <= fib_next_r;
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.ovf      = ovf_r;
  assign bus.fib      = fib_r;
  assign bus.fib_next = fib_next_r;

endmodule

// File: tb/tb_fib_matpow_seq.sv
// Directed bench for fib_matpow_seq: a 32-bit instance and a 16-bit instance
// sharing clock and reset. Latency is counted in rising edges from the cycle
// in which start is presented up to the cycle in which done is seen.
module tb_fib_matpow_seq;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  fib_matpow_seq_if #(.WIDTH(32), .NW(32)) bus_a ();
  fib_matpow_seq_if #(.WIDTH(16), .NW(16)) bus_b ();

  fib_matpow_seq #(.WIDTH(32), .NW(32), .OVF_LIMIT(47)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  fib_matpow_seq #(.WIDTH(16), .NW(16), .OVF_LIMIT(24)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_a(input logic [31:0] nv, output int lat, output int busy_cyc);
    lat = 0;
    busy_cyc = 0;
    @(negedge clk);
    bus_a.start = 1'b1;
    bus_a.n     = nv;
    while (lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (lat == 1) bus_a.start = 1'b0;
      if (bus_a.busy) busy_cyc++;
      if (bus_a.done) break;
    end
    check("done_seen_a", {63'd0, bus_a.done}, 64'd1);
  endtask

  task automatic run_b(input logic [15:0] nv, output int lat);
    lat = 0;
    @(negedge clk);
    bus_b.start = 1'b1;
    bus_b.n     = nv;
    while (lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (lat == 1) bus_b.start = 1'b0;
      if (bus_b.done) break;
    end
    check("done_seen_b", {63'd0, bus_b.done}, 64'd1);
  endtask

  // Directed sequence.
  initial begin
    int lat;
    int bcyc;
    int dones;
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b0;
    bus_a.start = 1'b0;
    bus_a.n     = 32'd0;
    bus_b.start = 1'b0;
    bus_b.n     = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Reset state
    check("rst_busy", {63'd0, bus_a.busy}, 64'd0);
    check("rst_done", {63'd0, bus_a.done}, 64'd0);
    check("rst_fib",  {32'd0, bus_a.fib}, 64'd0);
    check("rst_fibn", {32'd0, bus_a.fib_next}, 64'd0);
    check("rst_ovf",  {63'd0, bus_a.ovf}, 64'd0);

    // n = 0
    run_a(32'd0, lat, bcyc);
    check("n0_lat",  64'(lat), 64'd2);
    check("n0_busy", 64'(bcyc), 64'd1);
    check("n0_fib",  {32'd0, bus_a.fib}, 64'd0);
    check("n0_fibn", {32'd0, bus_a.fib_next}, 64'd1);
    check("n0_ovf",  {63'd0, bus_a.ovf}, 64'd0);

    // n = 10
    run_a(32'd10, lat, bcyc);
    check("n10_lat",  64'(lat), 64'd5);
    check("n10_fib",  {32'd0, bus_a.fib}, 64'd55);
    check("n10_fibn", {32'd0, bus_a.fib_next}, 64'd89);
    check("n10_ovf",  {63'd0, bus_a.ovf}, 64'd0);

    // n = 1
    run_a(32'd1, lat, bcyc);
    check("n1_lat",  64'(lat), 64'd2);
    check("n1_fib",  {32'd0, bus_a.fib}, 64'd1);
    check("n1_fibn", {32'd0, bus_a.fib_next}, 64'd1);

    // n = 47: largest non-overflowing index, F(48) wraps
    run_a(32'd47, lat, bcyc);
    check("n47_lat",  64'(lat), 64'd7);
    check("n47_fib",  {32'd0, bus_a.fib}, 64'd2971215073);
    check("n47_fibn", {32'd0, bus_a.fib_next}, 64'd512559680);
    check("n47_ovf",  {63'd0, bus_a.ovf}, 64'd0);

    // n = 48: overflow flagged
    run_a(32'd48, lat, bcyc);
    check("n48_fib",  {32'd0, bus_a.fib}, 64'd512559680);
    check("n48_fibn", {32'd0, bus_a.fib_next}, 64'd3483774753);
    check("n48_ovf",  {63'd0, bus_a.ovf}, 64'd1);

    // Results hold after done
    repeat (3) @(negedge clk);
    check("hold_done", {63'd0, bus_a.done}, 64'd0);
    check("hold_fib",  {32'd0, bus_a.fib}, 64'd512559680);
    check("hold_ovf",  {63'd0, bus_a.ovf}, 64'd1);

    // Start while busy is ignored
    @(negedge clk);
    bus_a.start = 1'b1;
    bus_a.n     = 32'd10;
    @(posedge clk);
    @(negedge clk);
    bus_a.n = 32'd3;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    bus_a.start = 1'b0;
    lat   = 3;
    dones = 0;
    while ((lat < 60) && !bus_a.done) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (bus_a.done) dones++;
    check("ign_lat",   64'(lat), 64'd5);
    check("ign_dones", 64'(dones), 64'd1);
    check("ign_fib",   {32'd0, bus_a.fib}, 64'd55);
    check("ign_fibn",  {32'd0, bus_a.fib_next}, 64'd89);

    // Start accepted in the DONE cycle
    bus_a.start = 1'b1;
    bus_a.n     = 32'd5;
    lat = 0;
    while (lat < 60) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (lat == 1) bus_a.start = 1'b0;
      if (bus_a.done) break;
    end
    check("bb_lat",  64'(lat), 64'd4);
    check("bb_fib",  {32'd0, bus_a.fib}, 64'd5);
    check("bb_fibn", {32'd0, bus_a.fib_next}, 64'd8);
    @(negedge clk);
    check("bb_pulse", {63'd0, bus_a.done}, 64'd0);

    // Reset during RUN aborts
    bus_a.start = 1'b1;
    bus_a.n     = 32'd1000;
    @(posedge clk);
    @(negedge clk);
    bus_a.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("ab_busy_run", {63'd0, bus_a.busy}, 64'd1);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("ab_busy", {63'd0, bus_a.busy}, 64'd0);
    check("ab_fib",  {32'd0, bus_a.fib}, 64'd0);
    check("ab_fibn", {32'd0, bus_a.fib_next}, 64'd0);
    check("ab_ovf",  {63'd0, bus_a.ovf}, 64'd0);
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_a.done) dones++;
    end
    check("ab_dones", 64'(dones), 64'd0);

    // Recovery after abort
    run_a(32'd2, lat, bcyc);
    check("n2_lat",  64'(lat), 64'd3);
    check("n2_fib",  {32'd0, bus_a.fib}, 64'd1);
    check("n2_fibn", {32'd0, bus_a.fib_next}, 64'd2);

    // 16-bit instance
    run_b(16'd24, lat);
    check("b24_lat",  64'(lat), 64'd6);
    check("b24_fib",  {48'd0, bus_b.fib}, 64'd46368);
    check("b24_fibn", {48'd0, bus_b.fib_next}, 64'd9489);
    check("b24_ovf",  {63'd0, bus_b.ovf}, 64'd0);
    run_b(16'd25, lat);
    check("b25_fib",  {48'd0, bus_b.fib}, 64'd9489);
    check("b25_fibn", {48'd0, bus_b.fib_next}, 64'd55857);
    check("b25_ovf",  {63'd0, bus_b.ovf}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
